// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the instruction cache
package cache_pkg;

  localparam int DEFAULT_S = 64;
  localparam int DEFAULT_B = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

endpackage

// File: rtl/instr_cache_if.sv
// rtl/instr_cache_if.sv - line-refill bus between instruction cache and memory
interface instr_cache_if;

  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRdata;
  logic        MemValid;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemRdata,
    input  MemValid
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemRdata,
    output MemValid
  );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - tag/valid/data storage: async lookup port, sync refill write port
module icache_array
  import cache_pkg::*;
#(
  parameter  int S     = DEFAULT_S,
  parameter  int B     = DEFAULT_B,
  localparam int W     = B / 4,
  localparam int IDX_W = $clog2(S),
  localparam int OFF_W = $clog2(W),
  localparam int TAG_W = 32 - IDX_W - $clog2(B)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic             valid_clr,
  input  logic             line_done,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [S-1:0]     valid;
  logic [TAG_W-1:0] tag_mem  [S];
  logic [31:0]      data_mem [S][W];

  always_comb begin
    hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
    rd_data = data_mem[rd_index][rd_offset];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index][wr_offset] <= wr_data;
    end
    if (line_done) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  // A line is invalid from its first refill beat until its last one lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (line_done) begin
      valid[wr_index] <= 1'b1;
    end else if (valid_clr) begin
      valid[wr_index] <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with line refill controller
module instr_cache
  import cache_pkg::*;
#(
  parameter int S = DEFAULT_S,
  parameter int B = DEFAULT_B
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   PCF,
  output logic [31:0]   InstrF,
  output logic          InstrMissF,
  output logic          InstrCacheRepActive,
  instr_cache_if.master mem
);

  localparam int W     = B / 4;
  localparam int LB    = $clog2(B);
  localparam int IDX_W = $clog2(S);
  localparam int OFF_W = $clog2(W);
  localparam int TAG_W = 32 - IDX_W - LB;

  state_t             state;
  state_t             state_next;
  logic [OFF_W-1:0]   count;
  logic [31:0]        line_addr;
  logic [IDX_W-1:0]   lat_index;

  logic [OFF_W-1:0]   pc_offset;
  logic [IDX_W-1:0]   pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic               hit;
  logic [31:0]        rd_data;
  logic               beat;
  logic               last_beat;

  assign pc_offset = PCF[LB-1:2];
  assign pc_index  = PCF[LB+IDX_W-1:LB];
  assign pc_tag    = PCF[31:LB+IDX_W];
  assign beat      = (state == REFILL) && mem.MemValid && !reset;
  assign last_beat = beat && (count == OFF_W'(W - 1));

  icache_array #(
    .S(S),
    .B(B)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (pc_index),
    .rd_tag    (pc_tag),
    .rd_offset (pc_offset),
    .hit       (hit),
    .rd_data   (rd_data),
    .wr_en     (beat),
    .wr_index  (lat_index),
    .wr_offset (count),
    .wr_data   (mem.MemRdata),
    .valid_clr (beat && (count == '0)),
    .line_done (last_beat),
    .wr_tag    (line_addr[31:LB+IDX_W])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are forced to their quiet values while reset is held, independent of state.
  always_comb begin
    state_next          = state;
    InstrF              = NOP;
    InstrMissF          = 1'b0;
    InstrCacheRepActive = 1'b0;
    mem.MemReq          = 1'b0;
    mem.MemAddr         = '0;
    case (state)
      IDLE:    if (!hit) state_next = REFILL;
      REFILL:  if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      InstrF              = hit ? rd_data : NOP;
      InstrMissF          = (state == REFILL) || !hit;
      InstrCacheRepActive = (state == REFILL);
      mem.MemReq          = (state == REFILL);
      mem.MemAddr         = line_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      line_addr <= '0;
      lat_index <= '0;
    end else begin
      if (state == IDLE && !hit) begin
        line_addr <= {PCF[31:LB], {LB{1'b0}}};
        lat_index <= pc_index;
      end
      if (beat) begin
        count <= last_beat ? '0 : count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - randomized scoreboard bench for instr_cache against a line-level model
module tb_instr_cache;
  import cache_pkg::*;

  localparam int NS = 64;
  localparam int NB = 16;
  localparam int NW = NB / 4;

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic        miss;
    logic        rep;
    logic        req;
    logic [31:0] addr;
    logic        chk_addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        InstrMissF;
  logic        InstrCacheRepActive;

  instr_cache_if bus ();

  instr_cache #(
    .S(NS),
    .B(NB)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .PCF                 (PCF),
    .InstrF              (InstrF),
    .InstrMissF          (InstrMissF),
    .InstrCacheRepActive (InstrCacheRepActive),
    .mem                 (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;

  // Model: each set remembers which line address it holds, plus that line's words.
  logic [31:0] m_line  [NS];
  bit          m_valid [NS];
  logic [31:0] m_data  [NS][NW];
  bit          m_refill;
  logic [31:0] m_fill_line;
  int          m_beats;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / NB) % NS);
  endfunction

  task automatic step(input logic r, input logic [31:0] pc, input logic mv);
    exp_t e;
    int   s;
    int   wd;
    bit   h;
    @(negedge clk);
    cycle++;
    reset        = r;
    PCF          = pc;
    bus.MemValid = mv;
    bus.MemRdata = m_refill ? mem_word(m_fill_line + 32'(4 * m_beats)) : $urandom;
    s  = set_of(pc);
    wd = int'(pc[3:2]);
    h  = m_valid[s] && (m_line[s] == (pc & ~32'(NB - 1)));
    e.cyc = cycle;
    if (r) begin
      e.instr = NOP; e.miss = 1'b0; e.rep = 1'b0; e.req = 1'b0;
      e.addr = 32'h0; e.chk_addr = 1'b1;
      for (int i = 0; i < NS; i++) m_valid[i] = 0;
      m_refill = 0;
      m_beats  = 0;
    end else if (!m_refill) begin
      e.instr = h ? m_data[s][wd] : NOP;
      e.miss = !h; e.rep = 1'b0; e.req = 1'b0; e.addr = 32'h0; e.chk_addr = 1'b0;
      if (!h) begin
        m_refill    = 1;
        m_fill_line = pc & ~32'(NB - 1);
        m_beats     = 0;
      end
    end else begin
      e.instr = h ? m_data[s][wd] : NOP;
      e.miss = 1'b1; e.rep = 1'b1; e.req = 1'b1; e.addr = m_fill_line; e.chk_addr = 1'b1;
      if (mv) begin
        if (m_beats == 0) m_valid[set_of(m_fill_line)] = 0;
        m_data[set_of(m_fill_line)][m_beats] = bus.MemRdata;
        m_beats++;
        if (m_beats == NW) begin
          m_line[set_of(m_fill_line)]  = m_fill_line;
          m_valid[set_of(m_fill_line)] = 1;
          m_refill = 0;
          m_beats  = 0;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("InstrF", e.cyc, InstrF, e.instr);
        check("InstrMissF", e.cyc, 32'(InstrMissF), 32'(e.miss));
        check("RepActive", e.cyc, 32'(InstrCacheRepActive), 32'(e.rep));
        check("MemReq", e.cyc, 32'(bus.MemReq), 32'(e.req));
        if (e.chk_addr) check("MemAddr", e.cyc, bus.MemAddr, e.addr);
      end
    end
  end

  initial begin
    logic [31:0] pc;
    reset        = 1'b1;
    PCF          = 32'h0;
    bus.MemValid = 1'b0;
    bus.MemRdata = 32'h0;
    m_refill     = 0;
    m_beats      = 0;
    m_fill_line  = 32'h0;
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0;
      m_line[i]  = 32'h0;
    end

    // Cold miss, then hit sweep across the line
    step(1, 32'h100, 0);
    step(1, 32'h100, 0);
    step(0, 32'h100, 0);
    for (int i = 0; i < NW; i++) step(0, 32'h100, 1);
    for (int i = 0; i < NW; i++) step(0, 32'h100 + 32'(4 * i), $urandom_range(0, 1));

    // Conflict on set 16, then refill the original line with gaps between beats
    step(0, 32'h500, 0);
    for (int i = 0; i < NW; i++) step(0, 32'h500, 1);
    step(0, 32'h504, 0);
    step(0, 32'h100, 0);
    for (int i = 0; i < 2 * NW; i++) step(0, 32'h100, i % 2 == 1);
    step(0, 32'h10C, 0);

    // Reset after two beats aborts the refill
    step(0, 32'h600, 0);
    step(0, 32'h600, 1);
    step(0, 32'h600, 1);
    step(1, 32'h600, 1);
    step(0, 32'h100, 1);
    for (int i = 0; i < NW; i++) step(0, 32'h100, 1);
    step(0, 32'h600, 0);
    for (int i = 0; i < NW; i++) step(0, 32'h600, 1);

    // PC moves away mid-refill: original line completes, new line misses next
    step(0, 32'h208, 0);
    step(0, 32'h200, 1);
    step(0, 32'h200, 1);
    step(0, 32'h300, 1);
    step(0, 32'h300, 1);
    step(0, 32'h200, 0);
    for (int i = 0; i < NW; i++) step(0, 32'h300, 1);
    step(0, 32'h208, 0);

    // Random traffic over a few sets with conflicting tags
    pc = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 3)
        pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      step($urandom_range(0, 199) == 0, pc, $urandom_range(0, 9) < 6);
    end

    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
